board_evaluator: RTL and testbench

//   Reads the nine 2-bit board cells held by the position register and decides the game outcome.
//   On a start pulse it snapshots the board and scans the 8 winning lines, one line per clock.
//   It reports winner, draw and the set of winning lines with a one-cycle done pulse.

---
 rtl/ttt_pkg.sv | 42 ++++
 rtl/ttt_line_select.sv | 26 ++
 rtl/board_evaluator.sv | 109 ++++++++++
 tb/tb_board_evaluator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, the winning-line table and the evaluator states.
// Used by the position register, the board evaluator and the game controller.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned NUM_CELLS = 9;

  typedef logic [3:0] cell_idx_t;

  typedef struct packed {
    cell_idx_t a;
    cell_idx_t b;
    cell_idx_t c;
  } line_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  // Zero-based cell indices (row-major) of each winning line.
  function automatic line_t line_cells(input logic [2:0] idx);
    line_t l;
    case (idx)
      3'd0:    l = '{a: 4'd0, b: 4'd1, c: 4'd2};
      3'd1:    l = '{a: 4'd3, b: 4'd4, c: 4'd5};
      3'd2:    l = '{a: 4'd6, b: 4'd7, c: 4'd8};
      3'd3:    l = '{a: 4'd0, b: 4'd3, c: 4'd6};
      3'd4:    l = '{a: 4'd1, b: 4'd4, c: 4'd7};
      3'd5:    l = '{a: 4'd2, b: 4'd5, c: 4'd8};
      3'd6:    l = '{a: 4'd0, b: 4'd4, c: 4'd8};
      default: l = '{a: 4'd2, b: 4'd4, c: 4'd6};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ttt_line_select.sv
// Combinational selector: picks the three cells of winning line idx out of the packed board
// snapshot (cell k of the board at bits [2k+1:2k]).
module ttt_line_select
  import ttt_pkg::*;
(
  input  logic [2:0]  idx,
  input  logic [17:0] snapshot,
  output logic [1:0]  cell_a,
  output logic [1:0]  cell_b,
  output logic [1:0]  cell_c
);

  logic [1:0] cells [NUM_CELLS];
  line_t      sel;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      cells[i] = snapshot[2*i +: 2];
    end
    sel    = line_cells(idx);
    cell_a = cells[sel.a];
    cell_b = cells[sel.b];
    cell_c = cells[sel.c];
  end

endmodule

// File: rtl/board_evaluator.sv
// Snapshots the board on start, scans the eight winning lines one per clock, then reports
// winner, draw and the set of owned lines with a one-cycle done pulse.
module board_evaluator
  import ttt_pkg::*;
#(
  parameter logic [1:0] P1_CODE    = CELL_P1,
  parameter logic [1:0] P2_CODE    = CELL_P2,
  parameter logic [1:0] EMPTY_CODE = CELL_EMPTY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       draw,
  output logic [7:0] win_lines,
  output logic       game_over
);

  state_t      state;
  logic [2:0]  idx;
  logic [17:0] snapshot;
  logic [1:0]  cell_a, cell_b, cell_c;
  logic        line_match;
  logic        board_full;

  ttt_line_select u_line_select (
    .idx      (idx),
    .snapshot (snapshot),
    .cell_a   (cell_a),
    .cell_b   (cell_b),
    .cell_c   (cell_c)
  );

  always_comb begin
    line_match = (cell_a == cell_b) && (cell_b == cell_c) &&
                 ((cell_a == P1_CODE) || (cell_a == P2_CODE));
  end

  // The invalid code 2'b11 counts as occupied: only EMPTY_CODE keeps the board open.
  always_comb begin
    board_full = 1'b1;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (snapshot[2*i +: 2] == EMPTY_CODE) board_full = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      snapshot  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      winner    <= '0;
      draw      <= 1'b0;
      win_lines <= '0;
      game_over <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snapshot  <= {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
            idx       <= '0;
            winner    <= '0;
            draw      <= 1'b0;
            win_lines <= '0;
            game_over <= 1'b0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (line_match) begin
            win_lines[idx] <= 1'b1;
            // Lowest-index match owns the result; later lines never overwrite it.
            if (winner == '0) winner <= cell_a;
          end
          if (idx == 3'd7) begin
            idx   <= '0;
            state <= REPORT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        REPORT: begin
          draw      <= (winner == '0) && board_full;
          game_over <= (winner != '0) || board_full;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_evaluator.sv
// Self-checking bench for board_evaluator: fixed vector table, multi-cycle corner sequences,
// and random boards compared against a line-by-line reference model.
module tb_board_evaluator;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       busy, done, draw, game_over;
  logic [1:0] winner;
  logic [7:0] win_lines;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [1:0] winner;
    logic       draw;
    logic [7:0] lines;
    logic       game_over;
  } res_t;

  typedef struct {
    string       name;
    logic [17:0] board;
    res_t        exp;
  } vec_t;

  board_evaluator #(
    .P1_CODE    (2'b01),
    .P2_CODE    (2'b10),
    .EMPTY_CODE (2'b00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pos1      (pos1),
    .pos2      (pos2),
    .pos3      (pos3),
    .pos4      (pos4),
    .pos5      (pos5),
    .pos6      (pos6),
    .pos7      (pos7),
    .pos8      (pos8),
    .pos9      (pos9),
    .busy      (busy),
    .done      (done),
    .winner    (winner),
    .draw      (draw),
    .win_lines (win_lines),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] bd(input logic [1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9);
    return {c9, c8, c7, c6, c5, c4, c3, c2, c1};
  endfunction

  function automatic res_t mk(input logic [1:0] w, input logic d, input logic [7:0] l,
                              input logic g);
    res_t r;
    r.winner = w; r.draw = d; r.lines = l; r.game_over = g;
    return r;
  endfunction

  // Reference: test every line by the game rules, first owner wins, draw if full and no winner.
  function automatic res_t model(input logic [17:0] b);
    int         ln [8][3];
    logic [1:0] c [1:9];
    res_t       r;
    bit         full;
    bit         have_winner;
    ln = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7}, '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
    for (int k = 1; k <= 9; k++) c[k] = b[2*(k-1) +: 2];
    r = mk(2'b00, 1'b0, 8'h00, 1'b0);
    have_winner = 0;
    for (int l = 0; l < 8; l++) begin
      if (c[ln[l][0]] == c[ln[l][1]] && c[ln[l][1]] == c[ln[l][2]] &&
          (c[ln[l][0]] == 2'b01 || c[ln[l][0]] == 2'b10)) begin
        r.lines[l] = 1'b1;
        if (!have_winner) begin
          have_winner = 1;
          r.winner = c[ln[l][0]];
        end
      end
    end
    full = 1;
    for (int k = 1; k <= 9; k++) if (c[k] == 2'b00) full = 0;
    r.draw      = !have_winner && full;
    r.game_over = have_winner || r.draw;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_res(input string name, input res_t e);
    chk({name, " winner"}, 32'(winner), 32'(e.winner));
    chk({name, " draw"}, 32'(draw), 32'(e.draw));
    chk({name, " win_lines"}, 32'(win_lines), 32'(e.lines));
    chk({name, " game_over"}, 32'(game_over), 32'(e.game_over));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " busy"}, 32'(busy), 0);
    chk({name, " done"}, 32'(done), 0);
    chk_res(name, mk(2'b00, 1'b0, 8'h00, 1'b0));
  endtask

  task automatic apply_board(input logic [17:0] b);
    {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} = b;
  endtask

  // Called #1 after an edge; returns edges counted since E0 until done is seen (bounded).
  task automatic wait_done(input string name, output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 9);
  endtask

  task automatic do_eval(input string name, input logic [17:0] b);
    int lat;
    apply_board(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " busy_after_start"}, 32'(busy), 1);
    wait_done(name, lat);
    chk({name, " busy_at_done"}, 32'(busy), 0);
  endtask

  vec_t vecs [8];
  res_t e;
  int   lat, ndone, first;
  logic [17:0] rb;

  initial begin
    vecs[0] = '{"empty",   bd(0,0,0,0,0,0,0,0,0), mk(2'b00, 0, 8'h00, 0)};
    vecs[1] = '{"row0_p1", bd(1,1,1,0,0,0,0,0,0), mk(2'b01, 0, 8'h01, 1)};
    vecs[2] = '{"draw",    bd(1,2,1,1,2,2,2,1,1), mk(2'b00, 1, 8'h00, 1)};
    vecs[3] = '{"two_p2",  bd(0,0,2,2,2,2,2,0,0), mk(2'b10, 0, 8'h82, 1)};
    vecs[4] = '{"illegal", bd(1,1,1,0,0,0,2,2,2), mk(2'b01, 0, 8'h05, 1)};
    vecs[5] = '{"all_inv", bd(3,3,3,3,3,3,3,3,3), mk(2'b00, 1, 8'h00, 1)};
    vecs[6] = '{"full_win",bd(1,2,1,1,2,2,2,2,1), mk(2'b10, 0, 8'h10, 1)};
    vecs[7] = '{"one_left",bd(1,2,1,1,2,2,2,1,0), mk(2'b00, 0, 8'h00, 0)};

    reset = 1'b1;
    start = 1'b0;
    apply_board('0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_eval(vecs[i].name, vecs[i].board);
      chk_res(vecs[i].name, vecs[i].exp);
      @(posedge clk); #1;
      chk({vecs[i].name, " done_one_cycle"}, 32'(done), 0);
    end

    // Results hold while idle, even with the board moving.
    apply_board(bd(2,2,2,2,2,2,2,2,2));
    repeat (5) @(posedge clk);
    #1;
    chk_res("hold", vecs[7].exp);

    // Start in the cycle done is high is accepted.
    do_eval("pre_back2back", vecs[1].board);
    apply_board(vecs[3].board);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("back2back busy", 32'(busy), 1);
    chk("back2back cleared", 32'(winner), 0);
    wait_done("back2back", lat);
    chk_res("back2back", vecs[3].exp);

    // Board change and start pulse during SCAN must not affect anything.
    apply_board(vecs[3].board);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    first = -1;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first < 0) first = c;
      end
      if (c == 2) start = 1'b1;
      if (c == 3) begin
        start = 1'b0;
        pos9  = 2'b10;
      end
    end
    chk("scan_start done_count", 32'(ndone), 1);
    chk("scan_start done_edge", 32'(first), 9);
    chk_res("snapshot", vecs[3].exp);

    // Reset in the middle of a scan.
    apply_board(vecs[4].board);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mid_reset no_done", 32'(ndone), 0);
    chk_all_zero("post_reset");
    do_eval("after_reset", vecs[2].board);
    chk_res("after_reset", vecs[2].exp);

    // Random boards against the reference model.
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 9; k++) begin
        rb[2*k +: 2] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      end
      e = model(rb);
      do_eval("random", rb);
      chk_res("random", e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
